// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converters: FSM state encoding,
// digit width and the minimum-binary-width helper used by elaboration checks.
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SHIFT,
      ADJUST,
      DONE
   } state_t;

   // Smallest n with 2**n >= 10**num_digits, i.e. enough bits for all-nines.
   function automatic int min_bin_bits(input int num_digits);
      longint unsigned limit;
      int              n;
      limit = 1;
      for (int i = 0; i < num_digits; i++) limit = limit * 10;
      n = 0;
      while ((64'd1 << n) < limit) n++;
      return n;
   endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Request/response bundle between a BCD digit source and the converter.
// The master presents packed BCD; the slave converts it and returns binary.
interface bcd_to_binary_if
   import bcd_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int NUM_BITS   = 14
) ();

   logic [BCD_DIGIT_W*NUM_DIGITS-1:0] packed_bcd_in;
   logic                              packed_bcd_in_valid;
   logic                              packed_bcd_in_ready;
   logic [NUM_BITS-1:0]               binary_out;
   logic                              binary_out_valid;
   logic                              bcd_error;

   modport master (
      output packed_bcd_in,
      output packed_bcd_in_valid,
      input  packed_bcd_in_ready,
      input  binary_out,
      input  binary_out_valid,
      input  bcd_error
   );

   modport slave (
      input  packed_bcd_in,
      input  packed_bcd_in_valid,
      output packed_bcd_in_ready,
      output binary_out,
      output binary_out_valid,
      output bcd_error
   );

endinterface

// File: rtl/bcd_to_binary_adjust.sv
// One-digit correction step of reverse double dabble: after a right shift a
// digit that reached 8 or more received a borrowed 10 as 16, so take 3 back.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BCD_DIGIT_W-1:0] digit_o
);

   assign digit_o = (digit_i >= BCD_DIGIT_W'(8)) ? digit_i - BCD_DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter (reverse double dabble, one result
// bit per SHIFT/ADJUST pair) with illegal-digit detection and valid/ready input.
module bcd_to_binary
   import bcd_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int NUM_BITS   = 14
) (
   input  logic          clk,
   input  logic          reset,
   bcd_to_binary_if.slave bus
);

   localparam int                 BCD_W      = BCD_DIGIT_W * NUM_DIGITS;
   localparam int                 COUNT_W    = $clog2(BCD_W + 1);
   localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(BCD_W);

   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("bcd_to_binary: NUM_DIGITS must be in 1..8");
   end
   if (NUM_BITS < min_bin_bits(NUM_DIGITS) || NUM_BITS > BCD_W) begin : g_bad_bits
      $error("bcd_to_binary: NUM_BITS too small for NUM_DIGITS or wider than the shift register");
   end

   state_t              state_q, state_d;
   logic [BCD_W-1:0]    bcd_q, bcd_d;
   logic [BCD_W-1:0]    bin_q, bin_d;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic                err_q, err_d;
   logic [NUM_BITS-1:0] out_q, out_d;
   logic                out_valid_q, out_valid_d;
   logic                bcd_error_q, bcd_error_d;

   logic [BCD_W-1:0]    adj_bcd;
   logic                digit_bad;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adjust
      bcd_digit_adjust u_adjust (
         .digit_i (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_o (adj_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   always_comb begin
      digit_bad = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(9)) digit_bad = 1'b1;
      end
   end

   always_comb begin
      // NOTE: every output of this block is given a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d     = state_q;
      bcd_d       = bcd_q;
      bin_d       = bin_q;
      count_d     = count_q;
      err_d       = err_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      bcd_error_d = bcd_error_q;

      case (state_q)
         IDLE: begin
            if (bus.packed_bcd_in_valid) begin
               bcd_d   = bus.packed_bcd_in;
               bin_d   = '0;
               count_d = '0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            err_d   = digit_bad;
            state_d = digit_bad ? DONE : SHIFT;
         end
         SHIFT: begin
            {bcd_d, bin_d} = {bcd_q, bin_q} >> 1;
            count_d        = count_q + 1'b1;
            state_d        = ADJUST;
         end
         ADJUST: begin
            bcd_d   = adj_bcd;
            state_d = (count_q == LAST_COUNT) ? DONE : SHIFT;
         end
         DONE: begin
            out_d       = err_q ? '0 : bin_q[NUM_BITS-1:0];
            bcd_error_d = err_q;
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         err_q       <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         bcd_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         err_q       <= err_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         bcd_error_q <= bcd_error_d;
      end
   end

   // NOTE: the shift registers are always loaded on accept before being read,
   // so they carry no reset and sit in their own process without one.
   always_ff @(posedge clk) begin
      bcd_q <= bcd_d;
      bin_q <= bin_d;
   end

   assign bus.packed_bcd_in_ready = (state_q == IDLE);
   assign bus.binary_out          = out_q;
   assign bus.binary_out_valid    = out_valid_q;
   assign bus.bcd_error           = bcd_error_q;

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential packed-BCD to binary converter using reverse double dabble (shift-right / subtract-3), one bit per two cycles.
- Inverse of the team's binary-to-BCD converter. Sits between seven-segment / keypad digit entry and binary datapath logic.
- Uses a single-transaction valid/ready handshake.
- Flags illegal BCD digits instead of converting them.

Parameters:
- NUM_DIGITS, 4, number of packed BCD digits at the input (1..8).
- NUM_BITS, 14, binary output width. Must be >= ceil(log2(10^NUM_DIGITS)); 14 covers 9999. Checked by elaboration assertion.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- packed_bcd_in  input  4*NUM_DIGITS  packed BCD; digit 0 in [3:0]
- packed_bcd_in_valid  input  1  request; accepted only when packed_bcd_in_ready=1
- packed_bcd_in_ready  output  1  high only in IDLE; combinational decode of state
- binary_out  output  NUM_BITS  converted value; registered; holds between completions
- binary_out_valid  output  1  one-cycle completion pulse
- bcd_error  output  1  qualified by binary_out_valid; 1 = input had a digit > 9

Behaviour:
- Reset (synchronous, active-high; clock clk) values:
  - state=IDLE, binary_out=0, binary_out_valid=0, bcd_error=0, count=0.
  - packed_bcd_in_ready=1 from the first cycle after reset.
- Internal registers:
  - bcd_reg (4*NUM_DIGITS bits).
  - bin_reg (4*NUM_DIGITS bits; low NUM_BITS are output).
  - count ($clog2(4*NUM_DIGITS+1) bits).
- FSM states: IDLE, CHECK, SHIFT, ADJUST, DONE.
- IDLE:
  - binary_out_valid defaults to 0 in every state except as set by DONE.
  - On valid && ready: bcd_reg<=packed_bcd_in, bin_reg<=0, count<=0 -> CHECK.
- CHECK:
  - If any digit of bcd_reg > 9: set err flag, go to DONE.
  - Otherwise clear err flag, go to SHIFT.
- SHIFT:
  - {bcd_reg,bin_reg} <= {bcd_reg,bin_reg} >> 1; count<=count+1; go to ADJUST.
- ADJUST:
  - Each bcd_reg digit >= 8 is decremented by 3, all digits in parallel.
  - If count == 4*NUM_DIGITS go to DONE, else go to SHIFT.
- DONE:
  - binary_out <= err ? 0 : bin_reg[NUM_BITS-1:0]; bcd_error<=err; binary_out_valid<=1 (visible next cycle); go to IDLE.
- Latency, counted from the accepting edge to the first edge at which binary_out_valid=1:
  - Legal input: 1 (CHECK) + 2*4*NUM_DIGITS + 1 (DONE) + 1 = 35 cycles for NUM_DIGITS=4.
  - Illegal input: 3 cycles.
- Throughput: one conversion per 35 cycles.
  - ready is high in the same cycle binary_out_valid pulses, so back-to-back requests are accepted there.
- Boundary conditions:
  - valid while busy is ignored; the input is not latched and needs no hold by the source.
  - A valid held high continuously restarts a conversion at each IDLE.
  - After the final shift bcd_reg is 0; the final ADJUST is a no-op.
  - Legal BCD stays legal through ADJUST.
  - All 4*NUM_DIGITS result bits above NUM_BITS are guaranteed 0 by the parameter constraint.
  - Reset mid-conversion aborts immediately: no valid pulse, and binary_out returns to 0.
  - Reset wins over a simultaneous request.
  - binary_out/bcd_error change only in DONE (or reset); they stay stable while busy.

Decomposition:
- Package bcd_pkg:
  - state_t enum (IDLE, CHECK, SHIFT, ADJUST, DONE).
  - BCD_DIGIT_W=4.
  - Constant function min_bin_bits(num_digits) for the elaboration check.
  - This package is shared with the binary-to-BCD converter.
- Sub-module bcd_digit_adjust: 4-bit combinational, d >= 8 ? d-3 : d. Instantiated NUM_DIGITS times via generate.
- All other logic lives in one always_ff FSM.

Test Plan:
- 0x1234 with valid, ready=1 -> binary_out=0x04D2 (1234), bcd_error=0, valid pulse exactly 35 cycles after accept, 1 cycle wide.
- 0x9999 -> 0x270F (9999); 0x0000 -> 0x0000; 0x0001 -> 0x0001; all bcd_error=0.
- 0x12A4 (digit 1 = 0xA) -> binary_out=0, bcd_error=1, valid 3 cycles after accept. The next legal 0x0042 -> 42 with bcd_error=0.
- Accept 0x0500, then drive 0x0777 valid during busy -> result 500 only. Then a new request in the valid-pulse cycle (0x0777) is accepted -> 777.
- Reset at cycle 10 of converting 0x8888 -> no valid pulse, binary_out=0, ready=1 the cycle after reset. A fresh 0x0099 -> 99.
- Randomized sweep of all 0..9999 against a reference model, with an assertion that binary_out stays stable while ready=0.
